npc_pc_unit: RTL and testbench

//  Consumer end of the decoder's Branch/Jump/R31Wr interface: owns the PC register and computes next-PC each cycle.

---
 rtl/npc_pkg.sv | 41 ++++
 rtl/npc_cond.sv | 38 +++
 rtl/npc_pc_unit.sv | 160 ++++++++++++++++
 tb/tb_npc_pc_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// ============================================================================
//  Module : npc_pkg
//  Brief  : Shared Branch/Jump decode codes, PC-unit FSM encoding and reset
//           and exception vectors for the next-PC unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package npc_pkg;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_EQ   = 3'b001;
    localparam logic [2:0] BR_NE   = 3'b010;
    localparam logic [2:0] BR_GEZ  = 3'b011;
    localparam logic [2:0] BR_GTZ  = 3'b100;
    localparam logic [2:0] BR_LEZ  = 3'b101;
    localparam logic [2:0] BR_LTZ  = 3'b110;
    localparam logic [2:0] BR_RSVD = 3'b111;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;
    localparam logic [1:0] JMP_RSVD = 2'b11;

    localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VEC  = 32'h0000_4180;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } npc_state_e;

    // Word-scaled, sign-extended branch displacement.
    function automatic logic [31:0] branch_off(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/npc_cond.sv
// ============================================================================
//  Module : npc_cond
//  Brief  : Combinational branch-condition evaluator (rs vs rt / rs vs zero).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module npc_cond
    import npc_pkg::*;
(
    input  logic [2:0]  branch,
    input  logic [31:0] ra_val,
    input  logic [31:0] rb_val,
    output logic        cond
);

    logic w_neg;
    logic w_zero;

    assign w_neg  = ra_val[31];
    assign w_zero = (ra_val == 32'd0);

    always_comb begin
        cond = 1'b0;
        case (branch)
            BR_EQ:   cond = (ra_val == rb_val);
            BR_NE:   cond = (ra_val != rb_val);
            BR_GEZ:  cond = !w_neg;
            BR_GTZ:  cond = !w_neg && !w_zero;
            BR_LEZ:  cond = w_neg || w_zero;
            BR_LTZ:  cond = w_neg;
            default: cond = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/npc_pc_unit.sv
// ============================================================================
//  Module : npc_pc_unit
//  Brief  : PC register and next-PC selection (branch, jump, exception, ERET).
//           Define NPC_DELAY_SLOT_EN for one-instruction delayed redirects.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module npc_pc_unit
    import npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter logic [31:0] EXC_VEC  = NPC_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [2:0]  branch,
    input  logic [1:0]  jump,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] ra_val,
    input  logic [31:0] rb_val,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc_in,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic [31:0] link_addr,
    output logic        taken,
    output logic [31:0] epc_out,
    output logic        bd_out
);

    npc_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;

    logic [31:0] w_seq;
    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;
    logic [31:0] w_tgt;
    logic        w_cond;
    logic        w_run;
    logic        w_in_slot;
    logic        w_redirect;

`ifdef NPC_DELAY_SLOT_EN
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    assign w_in_slot = pend_vld_q;
    assign link_addr = pc_q + 32'd8;
`else
    assign w_in_slot = 1'b0;
    assign link_addr = pc_q + 32'd4;
`endif

    npc_cond u_cond (
        .branch (branch),
        .ra_val (ra_val),
        .rb_val (rb_val),
        .cond   (w_cond)
    );

    assign w_seq  = pc_q + 32'd4;
    assign w_btgt = w_seq + branch_off(imm16);
    assign w_jtgt = {w_seq[31:28], target26, 2'b00};
    assign w_tgt  = (jump == JMP_J)  ? w_jtgt :
                    (jump == JMP_JR) ? ra_val : w_btgt;

    // The delay-slot instruction may not start a second redirect.
    assign w_run      = (state_q == ST_RUN);
    assign w_redirect = w_run && !w_in_slot &&
                        ((jump == JMP_J) || (jump == JMP_JR) || w_cond);

    assign pc       = pc_q;
    assign fetch_en = w_run;
    assign taken    = w_redirect;
    assign epc_out  = epc_q;
    assign bd_out   = bd_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        bd_d    = bd_q;
`ifdef NPC_DELAY_SLOT_EN
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
`endif
        if (exc_req) begin
            state_d = ST_FLUSH;
            pc_d    = EXC_VEC;
            epc_d   = w_in_slot ? (pc_q - 32'd4) : pc_q;
            bd_d    = w_in_slot;
`ifdef NPC_DELAY_SLOT_EN
            pend_vld_d = 1'b0;
`endif
        end else if (eret_req) begin
            state_d = ST_FLUSH;
            pc_d    = epc_in;
`ifdef NPC_DELAY_SLOT_EN
            pend_vld_d = 1'b0;
`endif
        end else if (!stall) begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_FLUSH: state_d = ST_RUN;
                ST_RUN: begin
`ifdef NPC_DELAY_SLOT_EN
                    if (pend_vld_q) begin
                        pc_d       = pend_tgt_q;
                        pend_vld_d = 1'b0;
                    end else if (w_redirect) begin
                        pc_d       = w_seq;
                        pend_tgt_d = w_tgt;
                        pend_vld_d = 1'b1;
                    end else begin
                        pc_d = w_seq;
                    end
`else
                    pc_d = w_redirect ? w_tgt : w_seq;
`endif
                end
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            bd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            bd_q    <= bd_d;
        end
    end

`ifdef NPC_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'd0;
        end else begin
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_npc_pc_unit.sv
// ============================================================================
//  Module : tb_npc_pc_unit
//  Brief  : Self-checking bench for npc_pc_unit (honours NPC_DELAY_SLOT_EN).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_npc_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  branch = 3'd0;
    logic [1:0]  jump = 2'd0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] target26 = 26'd0;
    logic [31:0] ra_val = 32'd0;
    logic [31:0] rb_val = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret_req = 1'b0;
    logic [31:0] epc_in = 32'd0;
    logic [31:0] pc;
    logic        fetch_en;
    logic [31:0] link_addr;
    logic        taken;
    logic [31:0] epc_out;
    logic        bd_out;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: mode 0=boot, 1=running, 2=flush; queue of deferred targets.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_bd;
    int          m_mode;
    logic [31:0] m_pendq[$];

`ifdef NPC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    npc_pc_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .branch    (branch),
        .jump      (jump),
        .imm16     (imm16),
        .target26  (target26),
        .ra_val    (ra_val),
        .rb_val    (rb_val),
        .exc_req   (exc_req),
        .eret_req  (eret_req),
        .epc_in    (epc_in),
        .pc        (pc),
        .fetch_en  (fetch_en),
        .link_addr (link_addr),
        .taken     (taken),
        .epc_out   (epc_out),
        .bd_out    (bd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit m_cond(input logic [2:0] b, input logic [31:0] a, input logic [31:0] c);
        int signed sa;
        sa = $signed(a);
        case (b)
            3'd1:    return a == c;
            3'd2:    return a != c;
            3'd3:    return sa >= 0;
            3'd4:    return sa > 0;
            3'd5:    return sa <= 0;
            3'd6:    return sa < 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_taken();
        if (m_mode != 1 || m_pendq.size() != 0) return 1'b0;
        return (jump == 2'd1) || (jump == 2'd2) || m_cond(branch, ra_val, rb_val);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] seq;
        int signed   off;
        seq = m_pc + 32'd4;
        off = $signed(imm16);
        if (jump == 2'd1) return {seq[31:28], target26, 2'b00};
        if (jump == 2'd2) return ra_val;
        return seq + (off * 4);
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        m_epc  = 32'd0;
        m_bd   = 1'b0;
        m_mode = 0;
        m_pendq.delete();
    endtask

    task automatic model_edge();
        bit          tk;
        bit          slot;
        logic [31:0] tg;
        tk   = m_taken();
        tg   = m_target();
        slot = (m_pendq.size() != 0);
        if (exc_req) begin
            m_epc  = slot ? m_pc - 32'd4 : m_pc;
            m_bd   = slot;
            m_pc   = 32'h0000_4180;
            m_mode = 2;
            m_pendq.delete();
        end else if (eret_req) begin
            m_pc   = epc_in;
            m_mode = 2;
            m_pendq.delete();
        end else if (!stall) begin
            if (m_mode != 1) m_mode = 1;
            else if (slot) m_pc = m_pendq.pop_front();
            else if (tk && DS) begin
                m_pendq.push_back(tg);
                m_pc = m_pc + 32'd4;
            end else m_pc = tk ? tg : m_pc + 32'd4;
        end
    endtask

    // One clock: drive at the falling edge, check combinational view, then advance.
    task automatic step(input logic s, input logic [2:0] b, input logic [1:0] j,
                        input logic [15:0] im, input logic [25:0] t, input logic [31:0] a,
                        input logic [31:0] c, input logic e, input logic r, input logic [31:0] ep);
        stall = s; branch = b; jump = j; imm16 = im; target26 = t;
        ra_val = a; rb_val = c; exc_req = e; eret_req = r; epc_in = ep;
        #1;
        chk("pc", pc, m_pc);
        chk("fetch_en", {31'd0, fetch_en}, {31'd0, m_mode == 1});
        chk("taken", {31'd0, taken}, {31'd0, m_taken()});
        chk("link_addr", link_addr, m_pc + (DS ? 32'd8 : 32'd4));
        chk("epc_out", epc_out, m_epc);
        chk("bd_out", {31'd0, bd_out}, {31'd0, m_bd});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 2'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic goto_pc(input logic [31:0] a);
        step(1'b0, 3'd0, 2'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, a);
        idle();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_fetch_en", {31'd0, fetch_en}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_epc", epc_out, 32'd0);
        chk("rst_bd", {31'd0, bd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        model_reset();

        reset_dut();
        idle();
        chk("boot_pc", pc, 32'h0000_3000);
        chk("boot_fetch_en", {31'd0, fetch_en}, 32'd1);
        idle();
        chk("first_seq", pc, 32'h0000_3004);

        reset_dut();
        idle();
        step(1'b0, 3'd6, 2'd0, 16'h0010, 26'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'd0);
        if (DS) begin
            chk("bltz_slot", pc, 32'h0000_3004);
            idle();
        end
        chk("bltz_pc", pc, 32'h0000_3044);

        reset_dut();
        idle();
        step(1'b0, 3'd3, 2'd0, 16'h0010, 26'd0, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("bgez_pc", pc, 32'h0000_3004);

        goto_pc(32'h0000_3010);
        step(1'b0, 3'd1, 2'd0, 16'hFFFC, 26'd0, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0);
        if (DS) begin
            chk("beq_slot", pc, 32'h0000_3014);
            idle();
        end
        chk("beq_pc", pc, 32'h0000_3004);

        goto_pc(32'h0000_3008);
        chk("jal_link", link_addr, DS ? 32'h0000_3010 : 32'h0000_300C);
        step(1'b0, 3'd0, 2'd1, 16'd0, 26'h0000C10, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        if (DS) idle();
        chk("jal_pc", pc, 32'h0000_3040);

        goto_pc(32'h0000_3020);
        step(1'b1, 3'd0, 2'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b1, 32'h0000_3024);
        chk("exc_pc", pc, 32'h0000_4180);
        chk("exc_epc", epc_out, 32'h0000_3020);
        chk("exc_fetch_en", {31'd0, fetch_en}, 32'd0);
        step(1'b0, 3'd0, 2'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_3024);
        chk("eret_pc", pc, 32'h0000_3024);

        if (DS) begin
            goto_pc(32'h0000_3100);
            step(1'b0, 3'd0, 2'd2, 16'd0, 26'd0, 32'h0000_5000, 32'd0, 1'b0, 1'b0, 32'd0);
            step(1'b0, 3'd0, 2'd0, 16'd0, 26'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
            chk("exc_slot_epc", epc_out, 32'h0000_3100);
            chk("exc_slot_bd", {31'd0, bd_out}, 32'd1);
        end

        goto_pc(32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc, 32'h0000_0000);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom();
            if ($urandom_range(0, 7) == 0) a = 32'd0;
            step($urandom_range(0, 99) < 15,
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 25) ? 2'($urandom_range(1, 3)) : 2'd0,
                 16'($urandom()), 26'($urandom()), a,
                 ($urandom_range(0, 3) == 0) ? a : $urandom(),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 3, $urandom());
        end

        // Asynchronous reset while a redirect is outstanding.
        goto_pc(32'h0000_3100);
        step(1'b0, 3'd0, 2'd1, 16'd0, 26'h0000C10, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_pc", pc, 32'h0000_3000);
        chk("async_rst_fetch_en", {31'd0, fetch_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        chk("pending_dropped", pc, 32'h0000_3004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
